// File: rtl/cr_fetcher.sv
// Triple prefetcher: issues counter bursts to a share generator and buffers the
// returned {a,b,c} triples in a first-word-fall-through FIFO for the consumer.
package cr_fetcher_pkg;
    localparam int CNT_W  = 16;
    localparam int PRNG_W = 16;
    typedef logic [CNT_W-1:0]  cr_cnt_t;
    typedef logic [PRNG_W-1:0] prng_t;
endpackage

module cr_fetcher
    import cr_fetcher_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int BURST   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     en_i,
    input  cr_cnt_t                  cnt_base_i,
    output logic                     run_o,
    output cr_cnt_t                  cnt_start_o,
    output cr_cnt_t                  cnt_end_o,
    input  prng_t                    a_i,
    input  prng_t                    b_i,
    input  prng_t                    c_i,
    input  logic                     dvld_i,
    output prng_t                    a_o,
    output prng_t                    b_o,
    output prng_t                    c_o,
    output logic                     vld_o,
    input  logic                     rdy_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     busy_o,
    output logic                     err_o,
    output logic                     wrap_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(BURST) + 1;
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam int TW = 3 * PRNG_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          init_q, init_d;
    cr_cnt_t       next_q, next_d;
    cr_cnt_t       start_q, start_d;
    cr_cnt_t       end_q, end_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
    logic          wrap_q, wrap_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    logic          push, pop;
    logic [CNT_W:0] fit_sum, adv_sum;
    cr_cnt_t       issue_start;
    logic [TW-1:0] mem [DEPTH];
    logic [TW-1:0] head;

    // A burst whose last counter would overflow restarts at 1; counter 0 is never issued.
    assign fit_sum     = {1'b0, next_q} + (CNT_W+1)'(BURST - 1);
    assign issue_start = fit_sum[CNT_W] ? cr_cnt_t'(1) : next_q;
    assign adv_sum     = {1'b0, issue_start} + (CNT_W+1)'(BURST);

    assign pop = vld_o & rdy_i;

    always_comb begin
        state_d  = state_q;
        init_d   = init_q;
        next_d   = next_q;
        start_d  = start_q;
        end_d    = end_q;
        beat_d   = beat_q;
        wd_d     = wd_q;
        err_d    = err_q;
        wrap_d   = wrap_q;
        push     = 1'b0;

        // cnt_base_i is captured on the first cycle out of reset; no issue until then.
        if (init_q) begin
            init_d = 1'b0;
            next_d = (cnt_base_i == '0) ? cr_cnt_t'(1) : cnt_base_i;
        end

        unique case (state_q)
            S_IDLE: begin
                if (dvld_i) err_d = 1'b1;
                if (en_i && !init_q && level_q <= LW'(DEPTH - BURST)) begin
                    state_d = S_ISSUE;
                    start_d = issue_start;
                    end_d   = issue_start + cr_cnt_t'(BURST - 1);
                    wrap_d  = wrap_q | fit_sum[CNT_W] | adv_sum[CNT_W];
                    next_d  = adv_sum[CNT_W] ? cr_cnt_t'(1) : adv_sum[CNT_W-1:0];
                    beat_d  = '0;
                    wd_d    = '0;
                end
            end
            S_ISSUE: begin
                if (dvld_i) err_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dvld_i) begin
                    if (level_q != LW'(DEPTH)) push = 1'b1;
                    else                       err_d = 1'b1;
                    beat_d = beat_q + BW'(1);
                    wd_d   = '0;
                    if (beat_q == BW'(BURST - 1)) state_d = S_IDLE;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (!push && pop) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            init_q   <= 1'b1;
            next_q   <= '0;
            start_q  <= '0;
            end_q    <= '0;
            beat_q   <= '0;
            wd_q     <= '0;
            err_q    <= 1'b0;
            wrap_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            init_q   <= init_d;
            next_q   <= next_d;
            start_q  <= start_d;
            end_q    <= end_d;
            beat_q   <= beat_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
            wrap_q   <= wrap_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= {a_i, b_i, c_i};
    end

    // Head is gated by valid so storage contents never leak while empty or in reset.
    assign head        = mem[rd_ptr_q];
    assign vld_o       = (level_q != '0);
    assign a_o         = vld_o ? head[TW-1 -: PRNG_W]       : '0;
    assign b_o         = vld_o ? head[2*PRNG_W-1 -: PRNG_W] : '0;
    assign c_o         = vld_o ? head[PRNG_W-1:0]           : '0;
    assign level_o     = level_q;
    assign run_o       = (state_q == S_ISSUE);
    assign busy_o      = (state_q != S_IDLE);
    assign cnt_start_o = start_q;
    assign cnt_end_o   = end_q;
    assign err_o       = err_q;
    assign wrap_o      = wrap_q;
endmodule

// File: tb/tb_cr_fetcher.sv
// Directed bench for cr_fetcher with a behavioural generator (latency 27) driven
// from the main thread; expected values are hand-derived constants.
module tb_cr_fetcher;
    import cr_fetcher_pkg::*;

    localparam int DEPTH   = 64;
    localparam int BURST   = 16;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 27;

    logic    clk_i = 1'b0;
    logic    rst_n_i, en_i, run_o, dvld_i, vld_o, rdy_i, busy_o, err_o, wrap_o;
    cr_cnt_t cnt_base_i, cnt_start_o, cnt_end_o;
    prng_t   a_i, b_i, c_i, a_o, b_o, c_o;
    logic [$clog2(DEPTH):0] level_o;

    always #5 clk_i = ~clk_i;

    cr_fetcher #(.DEPTH(DEPTH), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .cnt_base_i(cnt_base_i),
        .run_o(run_o), .cnt_start_o(cnt_start_o), .cnt_end_o(cnt_end_o),
        .a_i(a_i), .b_i(b_i), .c_i(c_i), .dvld_i(dvld_i),
        .a_o(a_o), .b_o(b_o), .c_o(c_o), .vld_o(vld_o), .rdy_i(rdy_i),
        .level_o(level_o), .busy_o(busy_o), .err_o(err_o), .wrap_o(wrap_o)
    );

    int vec_cnt = 0;
    int miscmp_cnt = 0;

    // generator model state
    bit      gen_pend = 0;
    int      gen_delay, gen_left, gen_emit;
    int      gen_limit = BURST;
    cr_cnt_t gen_cnt;
    bit      man_vld = 0;
    int      run_count = 0, run_dbl = 0;
    bit      run_prev = 0;
    cr_cnt_t run_s[$], run_e[$];
    int      run_tab_s[4] = '{5, 21, 37, 53};
    int      run_tab_e[4] = '{20, 36, 52, 68};
    logic [15:0] e;
    int      n;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        if (run_o) begin
            run_count++;
            run_s.push_back(cnt_start_o);
            run_e.push_back(cnt_end_o);
            if (run_prev) run_dbl++;
            gen_pend  = 1;
            gen_delay = LAT;
            gen_cnt   = cnt_start_o;
            gen_left  = BURST;
            gen_emit  = 0;
        end
        run_prev = run_o;
        dvld_i = 1'b0;
        if (gen_pend) begin
            if (gen_delay > 0) gen_delay--;
            else if (gen_left > 0 && gen_emit < gen_limit) begin
                dvld_i = 1'b1;
                a_i = gen_cnt;
                b_i = gen_cnt ^ 16'hA5A5;
                c_i = ~gen_cnt;
                gen_cnt++;
                gen_left--;
                gen_emit++;
            end
            if (gen_left == 0) gen_pend = 0;
        end
        if (man_vld) begin
            dvld_i = 1'b1;
            a_i = 16'h1234; b_i = 16'h5678; c_i = 16'h9ABC;
        end
    endtask

    task automatic wait_runs(input int want, input int max);
        for (int i = 0; i < max && run_count < want; i++) step();
        chk("run_count", run_count, want);
    endtask

    task automatic wait_level(input int want, input int max);
        for (int i = 0; i < max && level_o != want; i++) step();
        chk("level_reach", level_o, want);
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && busy_o; i++) step();
        chk("idle_reach", busy_o, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_run"},   run_o, 0);
        chk({tag, "_start"}, cnt_start_o, 0);
        chk({tag, "_end"},   cnt_end_o, 0);
        chk({tag, "_vld"},   vld_o, 0);
        chk({tag, "_level"}, level_o, 0);
        chk({tag, "_busy"},  busy_o, 0);
        chk({tag, "_err"},   err_o, 0);
        chk({tag, "_wrap"},  wrap_o, 0);
        chk({tag, "_abc"},   {a_o, b_o}, 0);
        chk({tag, "_c"},     c_o, 0);
    endtask

    task automatic chk_head(input string tag, input int cnt);
        e = 16'(cnt);
        chk({tag, "_a"}, a_o, e);
        chk({tag, "_b"}, b_o, e ^ 16'hA5A5);
        chk({tag, "_c"}, c_o, 16'(~e));
    endtask

    initial begin
        rst_n_i = 0; en_i = 0; rdy_i = 0; cnt_base_i = 16'd5;
        dvld_i = 0; a_i = '0; b_i = '0; c_i = '0;
        step(); step();
        chk_reset("rst0");

        // fill from empty: four bursts, then stop at full
        rst_n_i = 1; en_i = 1;
        wait_runs(4, 300);
        wait_idle(100);
        for (int k = 0; k < 4 && k < run_s.size(); k++) begin
            chk($sformatf("run%0d_start", k), run_s[k], run_tab_s[k]);
            chk($sformatf("run%0d_end", k), run_e[k], run_tab_e[k]);
        end
        for (int i = 0; i < 10; i++) step();
        chk("full_level", level_o, 64);
        chk("full_runs", run_count, 4);
        chk("full_vld", vld_o, 1);
        chk("full_err", err_o, 0);
        chk("full_wrap", wrap_o, 0);
        chk_head("full_head", 5);

        // pop 16, refill issues on the following cycle
        rdy_i = 1;
        for (int i = 0; i < 16; i++) begin
            chk_head($sformatf("pop%0d", i), 5 + i);
            step();
        end
        rdy_i = 0;
        chk("pop_level", level_o, 48);
        chk("pop_run_low", run_o, 0);
        step();
        chk("refill_runs", run_count, 5);
        chk("refill_start", cnt_start_o, 69);
        chk("refill_end", cnt_end_o, 84);
        en_i = 0;
        wait_idle(100);
        chk("refill_level", level_o, 64);

        // drain everything; pointers have wrapped by now
        rdy_i = 1;
        for (int i = 0; i < 64; i++) begin
            chk_head($sformatf("drain%0d", i), 21 + i);
            step();
        end
        rdy_i = 0;
        chk("drain_level", level_o, 0);
        chk("drain_vld", vld_o, 0);
        chk("drain_a", a_o, 0);
        chk("en_off_runs", run_count, 5);

        // simultaneous push and pop at level 1
        en_i = 1;
        wait_runs(6, 10);
        en_i = 0;
        chk("pp_start", cnt_start_o, 85);
        chk("pp_end", cnt_end_o, 100);
        wait_level(1, 60);
        rdy_i = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("pp_level", level_o, 1);
            chk("pp_vld", vld_o, 1);
            chk("pp_head", a_o, 86 + i);
        end
        wait_idle(40);
        for (int i = 0; i < 5 && vld_o; i++) step();
        rdy_i = 0;
        chk("pp_empty", level_o, 0);

        // generator stalls after 3 beats -> watchdog
        gen_limit = 3;
        en_i = 1;
        wait_runs(7, 10);
        en_i = 0;
        chk("st_start", cnt_start_o, 101);
        wait_level(3, 60);
        for (int i = 0; i < 40; i++) step();
        chk("st_busy_mid", busy_o, 1);
        chk("st_err_mid", err_o, 0);
        n = 0;
        for (int i = 0; i < 40 && busy_o; i++) begin step(); n++; end
        chk("st_to_cycles", n, TIMEOUT - 40);
        chk("st_busy", busy_o, 0);
        chk("st_err", err_o, 1);
        chk("st_level", level_o, 3);
        chk_head("st_head", 101);
        gen_limit = BURST;

        // reset in the middle of WAIT, base 0 -> first counter 1
        en_i = 1;
        wait_runs(8, 10);
        en_i = 0;
        chk("rw_start", cnt_start_o, 117);
        wait_level(8, 60);
        rst_n_i = 0; cnt_base_i = 16'd0; gen_pend = 0;
        step();
        chk_reset("rst1");
        rst_n_i = 1;
        for (int i = 0; i < 5; i++) step();
        chk("rel_busy", busy_o, 0);
        chk("rel_err", err_o, 0);

        // spurious beat in IDLE
        man_vld = 1;
        step();
        man_vld = 0;
        step();
        chk("sp_err", err_o, 1);
        chk("sp_level", level_o, 0);
        chk("sp_vld", vld_o, 0);
        en_i = 1;
        wait_runs(9, 10);
        en_i = 0;
        chk("b0_start", cnt_start_o, 1);
        chk("b0_end", cnt_end_o, 16);

        // base near the top of the counter range wraps to 1
        rst_n_i = 0; cnt_base_i = 16'hFFF5; gen_pend = 0;
        step();
        rst_n_i = 1;
        step(); step();
        chk("wr_pre", wrap_o, 0);
        en_i = 1;
        wait_runs(10, 10);
        en_i = 0;
        chk("wr_start", cnt_start_o, 1);
        chk("wr_end", cnt_end_o, 16);
        chk("wr_flag", wrap_o, 1);
        chk("run_width", run_dbl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end
endmodule

// File: doc/cr_fetcher.md
CR_FETCHER -- requirements
Module: cr_fetcher

Interface
REQ-001 Parameter DEPTH, default 64, meaning: triple FIFO depth in entries, power of two, at least 2*BURST.
REQ-002 Parameter BURST, default 16, meaning: triples requested per generator run, range 1..DEPTH/2.
REQ-003 Parameter TIMEOUT, default 64, meaning: cycles allowed after the last expected beat before a burst is abandoned.
REQ-004 clk_i  in  1  single clock; all logic is on its rising edge.
REQ-005 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-006 en_i  in  1  refill enable.
REQ-007 cnt_base_i  in  cr_cnt_t  first counter value; sampled while rst_n_i is low and on the cycle after reset release.
REQ-008 run_o  out  1  one-cycle start pulse to the generator.
REQ-009 cnt_start_o, cnt_end_o  out  cr_cnt_t each  burst counter bounds to the generator.
REQ-010 a_i, b_i, c_i  in  prng_t each  triple shares from the generator.
REQ-011 dvld_i  in  1  generator data valid; one triple per high cycle; no backpressure.
REQ-012 a_o, b_o, c_o  out  prng_t each  head-of-FIFO triple.
REQ-013 vld_o  out  1  head entry valid.
REQ-014 rdy_i  in  1  consumer accepts head.
REQ-015 level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-016 busy_o  out  1  burst in flight.
REQ-017 err_o  out  1  sticky error.
REQ-018 wrap_o  out  1  sticky counter wrap.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-020 IDLE->ISSUE SHALL occur when en_i=1 and level_o+BURST<=DEPTH.
REQ-021 In ISSUE, run_o SHALL be 1 for exactly one cycle, with cnt_start_o=next and cnt_end_o=next+BURST-1, and the FSM SHALL then go to WAIT.
REQ-022 cnt_start_o and cnt_end_o SHALL be registered and held stable from ISSUE until the next ISSUE.
REQ-023 next SHALL never be 0; a cnt_base_i of 0 SHALL load 1.
REQ-024 After each ISSUE, next SHALL advance by BURST; if next+BURST-1 would overflow cr_cnt_t, next SHALL become 1 and wrap_o SHALL set.
REQ-025 In WAIT, each dvld_i=1 cycle SHALL write {a_i,b_i,c_i} into the FIFO and increment a beat counter.
REQ-026 WAIT->IDLE SHALL occur on the cycle the BURST-th beat is written.
REQ-027 In WAIT, a watchdog SHALL count cycles without a beat; at TIMEOUT it SHALL set err_o and return to IDLE, keeping any beats already written.
REQ-028 A dvld_i=1 cycle while in IDLE or ISSUE SHALL be dropped and SHALL set err_o; the FIFO SHALL never overflow.
REQ-029 The FIFO SHALL be first-word-fall-through: vld_o=(level_o!=0), and a_o/b_o/c_o show the head combinationally from storage.
REQ-030 A pop SHALL occur when vld_o and rdy_i are both 1.
REQ-031 A simultaneous push and pop SHALL leave level_o unchanged; a push into an empty FIFO SHALL assert vld_o on the next cycle.
REQ-032 Read and write pointers SHALL wrap modulo DEPTH.
REQ-033 Deasserting en_i mid-burst SHALL NOT abort the burst; no new ISSUE SHALL occur while en_i=0.
REQ-034 busy_o SHALL be 1 in ISSUE and WAIT.

Reset
REQ-035 While rst_n_i=0, outputs SHALL be: run_o=0, cnt_start_o=0, cnt_end_o=0, vld_o=0, level_o=0, busy_o=0, err_o=0, wrap_o=0, a_o/b_o/c_o=0.
REQ-036 While rst_n_i=0, the FSM SHALL be in IDLE and the FIFO pointers, beat counter and watchdog SHALL be cleared.
REQ-037 Reset during WAIT SHALL discard the burst; dvld_i beats arriving after reset release SHALL be treated per REQ-028.

Verification
REQ-038 DEPTH=64, BURST=16, cnt_base_i=5, en_i=1, rdy_i=0, generator model with latency 27 -> run_o pulses with cnt_start_o/cnt_end_o = 5/20, 21/36, 37/52, 53/68; stops at level_o=64; triples stored in order.
REQ-039 Full FIFO, then rdy_i=1 for 16 cycles -> level_o=48, next ISSUE occurs the following cycle, and popped data order matches push order.
REQ-040 Push and pop in the same cycle at level_o=1 -> level_o stays 1 and vld_o stays 1.
REQ-041 cnt_base_i = max-10, BURST=16 -> wrap_o=1 and cnt_start_o=1.
REQ-042 Generator model stalls after 3 beats -> err_o=1 at TIMEOUT, level_o=3, FSM back to IDLE.
REQ-043 Spurious dvld_i in IDLE -> err_o=1, level_o unchanged; reset asserted mid-WAIT -> all REQ-035 values.
